// File: rtl/seq_signed_mult_ctrl.sv
// seq_signed_mult_ctrl
//   Sequencing controller and datapath for a sequential signed multiplier.
//   Two N-bit two's-complement operands are captured on a start/in_ready
//   handshake. A radix-2 Booth add/subtract-shift loop then runs for exactly
//   N iterations. The 2N-bit signed product is registered and flagged with a
//   one-cycle done pulse.
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous, active-high reset
//   start         begin a multiply (sampled only while in_ready=1)
//   multiplicand  signed operand M (N bits)
//   multiplier    signed operand Q (N bits)
//   in_ready      high in IDLE; start & in_ready at an edge accepts operands
//   busy          high while the Booth loop is running
//   done          one-cycle pulse; product is valid in this cycle
//   product       signed 2N-bit result; held until the next operation completes
module seq_signed_mult_ctrl #(
  parameter int N  = 8,
  parameter int CW = $clog2(N+1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic           in_ready,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nxt;

  // A carries one extra bit so that subtracting M = -2^(N-1) cannot overflow
  logic signed [N:0]     a_r;
  logic        [N-1:0]   q_r;
  logic                  q_m1_r;
  logic signed [N-1:0]   m_r;
  logic        [CW-1:0]  count_r;
  logic signed [2*N-1:0] product_r;

  logic signed [N:0]     a_nxt;
  logic        [N-1:0]   q_nxt;
  logic                  q_m1_nxt;
  logic                  last_step;

  // One Booth iteration: add/subtract M according to {Q[0], q_m1}, then
  // arithmetic right shift of {A', Q, q_m1}. The returned vector is the
  // shifted {A, Q, q_m1}; the old q_m1 falls off the bottom.
  function automatic logic [2*N+1:0] booth_step(
    input logic signed [N:0]   a,
    input logic        [N-1:0] q,
    input logic                qm1,
    input logic signed [N-1:0] m
  );
    logic signed [N:0] m_ext;
    logic signed [N:0] a_sum;
    m_ext = {m[N-1], m};
    case ({q[0], qm1})
      2'b01:   a_sum = a + m_ext;
      2'b10:   a_sum = a - m_ext;
      default: a_sum = a;
    endcase
    return {a_sum[N], a_sum, q};
  endfunction

  always_comb begin
    {a_nxt, q_nxt, q_m1_nxt} = booth_step(a_r, q_r, q_m1_r, m_r);
  end

  assign last_step = (count_r == CW'(N-1));

  // ---- control: state register ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // ---- control: next state and handshake outputs ----
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- datapath: operand capture, Booth iterations, result register ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_r       <= '0;
      q_r       <= '0;
      q_m1_r    <= 1'b0;
      m_r       <= '0;
      count_r   <= '0;
      product_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m_r     <= multiplicand;
            q_r     <= multiplier;
            a_r     <= '0;
            q_m1_r  <= 1'b0;
            count_r <= '0;
          end
        end
        RUN: begin
          a_r     <= a_nxt;
          q_r     <= q_nxt;
          q_m1_r  <= q_m1_nxt;
          count_r <= count_r + CW'(1);
          // The Nth shift leaves the full product in {A[N-1:0], Q}
          if (last_step) product_r <= {a_nxt[N-1:0], q_nxt};
        end
        default: ;
      endcase
    end
  end

  assign product = product_r;

endmodule

// File: doc/seq_signed_mult_ctrl.md
Name: seq_signed_mult_ctrl

Overview:
Sequencing controller and datapath for the sequential signed multiplier. It accepts two N-bit two's-complement operands on a start/ready handshake and runs a radix-2 Booth add/subtract-shift loop for exactly N iterations, tracked by an internal iteration counter. It then presents a 2N-bit signed product with a one-cycle done pulse. The block sits between the operand input registers and the result/display logic.

Parameters:
N, 8, operand width in bits (N >= 2); product width is 2N.
CW, $clog2(N+1), iteration counter width (derived; must not be overridden).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  request to begin a multiply; sampled only when in_ready=1.
multiplicand  input  N  signed operand M.
multiplier  input  N  signed operand Q.
in_ready  output  1  high in IDLE; a start is accepted when start & in_ready at a rising edge.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse; product is valid in this cycle.
product  output  2N  signed result register; holds its value until the next accepted start completes.

Behaviour:
- Reset (async, reset=1):
  - state=IDLE; A=0; Q=0; q_m1=0; M=0; count=0; product=0.
  - Outputs during reset: in_ready=1, busy=0, done=0.
- Registers:
  - A is N+1 bits, so that subtracting M=-2^(N-1) does not overflow.
  - Q is N bits; q_m1 is 1 bit; M is N bits, sign-extended to N+1 bits before use; count is CW bits.
- States: IDLE -> RUN -> DONE -> IDLE. All state and register updates occur on the rising edge.
- IDLE:
  - in_ready=1.
  - On start=1 at an edge: M<=multiplicand, Q<=multiplier, A<=0, q_m1<=0, count<=0, go to RUN.
  - With start=0: remain in IDLE; product is held.
- RUN (busy=1, in_ready=0): one Booth step per edge.
  - Select on {Q[0],q_m1}: 01 -> A' = A + M; 10 -> A' = A - M; 00 and 11 -> A' = A.
  - Then arithmetic-shift {A',Q,q_m1} right by one, replicating the sign bit of A'.
  - count<=count+1.
- RUN exit:
  - At the edge where count==N-1, the Nth step is performed.
  - On that same edge, product<={A_new[N-1:0],Q_new} and the state goes to DONE.
- DONE: done=1, busy=0, in_ready=0 for exactly one cycle; next edge -> IDLE.
- Latency:
  - A start accepted at edge t0 gives done=1 in the cycle between edges t0+N and t0+N+1.
  - Next accept is possible at edge t0+N+2 at the earliest.
- Ignored inputs:
  - start asserted in RUN or DONE is ignored; it is neither queued nor does it restart the operation.
  - Operand inputs are ignored after the accept edge; changes during RUN do not affect the result.
- Arithmetic: the result equals the exact signed product for all operand pairs, including -2^(N-1) * -2^(N-1) = +2^(2N-2).
- Reset mid-operation: immediate return to IDLE with all registers cleared (product=0); no done pulse is produced.
- done never asserts for two consecutive cycles; busy and done are never high together.

Test Plan:
- Reset, then start with M=3, Q=5 (N=8) accepted at t0 -> busy high for 8 cycles; done pulses once in cycle t0+8; product=16'd15; in_ready returns high the cycle after done.
- M=-7, Q=6 -> product=16'hFFD6 (-42). Then M=0, Q=-1 -> product=0.
- Corner values:
  - M=-128, Q=-128 -> product=16'h4000 (+16384).
  - M=127, Q=-128 -> 16'hC080 (-16256).
  - M=-1, Q=-1 -> 16'h0001.
- Start held high continuously, with operands changed every cycle during RUN -> only the first operand pair is multiplied; operations occur back-to-back at a period of N+2 cycles; done pulses are each 1 cycle wide.
- Assert reset asynchronously (between edges) at step 4 of a run -> outputs immediately show in_ready=1, busy=0, done=0, product=0. No done pulse follows. A subsequent start with 2*3 yields product=6.
- Random regression, 10k signed operand pairs at N=8 plus a sweep at N=4 -> product matches the reference signed multiply on every done pulse; done count equals accepted-start count.
